// File: rtl/aes_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes_seq_pkg
// Brief    : Shared encodings for the AES-128 round sequencer: FSM states,
//            mode and opcode values, and the key-schedule RCON table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package aes_seq_pkg;

   // Sequencer states
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_KS   = 3'd1;
   localparam logic [2:0] ST_ENC  = 3'd2;
   localparam logic [2:0] ST_DEC  = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   // Operation modes presented with start
   localparam logic [1:0] MODE_KS  = 2'b00;
   localparam logic [1:0] MODE_ENC = 2'b01;
   localparam logic [1:0] MODE_DEC = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   // Datapath opcodes
   localparam logic [2:0] OP_LOAD   = 3'd0;
   localparam logic [2:0] OP_XOR    = 3'd1;
   localparam logic [2:0] OP_ADDRK  = 3'd2;
   localparam logic [2:0] OP_ENCSSM = 3'd3;
   localparam logic [2:0] OP_ENCSS  = 3'd4;
   localparam logic [2:0] OP_INVMC  = 3'd5;
   localparam logic [2:0] OP_DECSSM = 3'd6;
   localparam logic [2:0] OP_DECSS  = 3'd7;

   // Round constants for rounds 1..10, round 1 in the low byte
   localparam int         RCON_ENTRIES = 10;
   localparam logic [79:0] RCON_TABLE  = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                          8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

endpackage
`default_nettype wire

// File: rtl/aes_rcon_rom.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes_rcon_rom
// Brief    : Round-constant lookup; index 1..10 selects RCON, anything else
//            returns 0x00.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module aes_rcon_rom
   import aes_seq_pkg::*;
(
   input  logic [3:0] idx,
   output logic [7:0] rcon
);

   logic [3:0] w_sel;
   logic [6:0] w_bit;

   // Table is stored round 1 first, so shift the 1-based index down by one
   always_comb begin
      w_sel = idx - 4'd1;
      w_bit = {w_sel, 3'b000};
      rcon  = 8'h00;
      if ((idx >= 4'd1) && (idx <= 4'(RCON_ENTRIES))) begin
         rcon = RCON_TABLE[w_bit +: 8];
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes128_round_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : aes128_round_seq
// Brief    : Issues the operation stream for an AES-128 round datapath:
//            key schedule, encryption and decryption over a valid/ready
//            handshake. Operation fields decode from state and round counter,
//            so they cannot move while a transfer is stalled.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module aes128_round_seq
   import aes_seq_pkg::*;
#(
   parameter int NR  = 10,
   parameter int OPW = 3
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     mode,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic           keys_valid,
   output logic           op_valid,
   input  logic           op_ready,
   output logic [OPW-1:0] op_code,
   output logic [3:0]     op_rk_idx,
   output logic [7:0]     op_rcon,
   output logic           op_rk_we
);

   localparam logic [3:0] c_nr = 4'(NR);

   logic [2:0] r_state;
   logic [3:0] r_cnt;
   logic       r_phase;      // decrypt: 0 = INVMC next, 1 = DECSSM next
   logic       r_ks_run;     // current sequence is a key schedule
   logic       r_err;
   logic       r_keys_valid;

   logic [2:0] w_code;
   logic [3:0] w_idx;
   logic       w_we;
   logic       w_last;
   logic       w_xfer;
   logic [7:0] w_rcon;

   aes_rcon_rom u_rcon (
      .idx  (r_cnt),
      .rcon (w_rcon)
   );

   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_FIN);
   assign err        = r_err;
   assign keys_valid = r_keys_valid;
   assign op_valid   = (r_state == ST_KS) || (r_state == ST_ENC) || (r_state == ST_DEC);
   assign w_xfer     = op_valid && op_ready;
   assign op_code    = OPW'(w_code);
   assign op_rk_idx  = w_idx;
   assign op_rk_we   = w_we;
   assign op_rcon    = ((r_state == ST_KS) && (w_code == OP_ADDRK)) ? w_rcon : 8'h00;

   // Decode the current operation from state, round counter and pair phase
   always_comb begin
      w_code = OP_LOAD;
      w_idx  = r_cnt;
      w_we   = 1'b0;
      w_last = 1'b0;
      case (r_state)
         ST_KS: begin
            w_code = (r_cnt == 4'd0) ? OP_LOAD : OP_ADDRK;
            w_we   = 1'b1;
            w_last = (r_cnt == c_nr);
         end
         ST_ENC: begin
            if (r_cnt == 4'd0)      w_code = OP_XOR;
            else if (r_cnt == c_nr) w_code = OP_ENCSS;
            else                    w_code = OP_ENCSSM;
            w_last = (r_cnt == c_nr);
         end
         ST_DEC: begin
            if (r_cnt == c_nr) begin
               w_code = OP_XOR;
            end else if (r_cnt == 4'd0) begin
               w_code = OP_DECSS;
               w_last = 1'b1;
            end else begin
               w_code = r_phase ? OP_DECSSM : OP_INVMC;
            end
         end
         default: begin
            w_idx = 4'd0;
         end
      endcase
   end

   // Sequencer FSM: start acceptance, per-transfer advance, completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_phase      <= 1'b0;
         r_ks_run     <= 1'b0;
         r_err        <= 1'b0;
         r_keys_valid <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_phase <= 1'b0;
                  if (mode == MODE_KS) begin
                     r_state      <= ST_KS;
                     r_cnt        <= 4'd0;
                     r_ks_run     <= 1'b1;
                     r_keys_valid <= 1'b0;
                  end else if ((mode == MODE_ENC) && r_keys_valid) begin
                     r_state  <= ST_ENC;
                     r_cnt    <= 4'd0;
                     r_ks_run <= 1'b0;
                  end else if ((mode == MODE_DEC) && r_keys_valid) begin
                     r_state  <= ST_DEC;
                     r_cnt    <= c_nr;
                     r_ks_run <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_KS, ST_ENC, ST_DEC: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_state <= ST_FIN;
                     r_cnt   <= 4'd0;
                     r_phase <= 1'b0;
                  end else if (r_state == ST_DEC) begin
                     if (r_cnt == c_nr) begin
                        r_cnt   <= c_nr - 4'd1;
                        r_phase <= 1'b0;
                     end else if (r_phase) begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_phase <= 1'b0;
                     end else begin
                        r_phase <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               if (r_ks_run) r_keys_valid <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 4'd0;
               r_phase <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_aes128_round_seq
// Brief    : Directed, table-driven bench for aes128_round_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aes128_round_seq;

   typedef struct {
      logic [2:0] code;
      logic [3:0] idx;
      logic [7:0] rcon;
      logic       we;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic       busy, done, err, keys_valid, op_valid, op_ready, op_rk_we;
   logic [2:0] op_code;
   logic [3:0] op_rk_idx;
   logic [7:0] op_rcon;

   int checks;
   int errors;
   vec_t vt [42];

   aes128_round_seq #(.NR(10), .OPW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .keys_valid (keys_valid),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_code    (op_code),
      .op_rk_idx  (op_rk_idx),
      .op_rcon    (op_rcon),
      .op_rk_we   (op_rk_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_op(input string name, input int n);
      chk({name, " valid"}, 32'(op_valid), 32'd1);
      chk({name, " code"},  32'(op_code),  32'(vt[n].code));
      chk({name, " idx"},   32'(op_rk_idx), 32'(vt[n].idx));
      chk({name, " rcon"},  32'(op_rcon),  32'(vt[n].rcon));
      chk({name, " we"},    32'(op_rk_we), 32'(vt[n].we));
      chk({name, " err"},   32'(err),      32'd0);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, " busy"},  32'(busy),      32'd0);
      chk({name, " done"},  32'(done),      32'd0);
      chk({name, " err"},   32'(err),       32'd0);
      chk({name, " valid"}, 32'(op_valid),  32'd0);
      chk({name, " code"},  32'(op_code),   32'd0);
      chk({name, " idx"},   32'(op_rk_idx), 32'd0);
      chk({name, " rcon"},  32'(op_rcon),   32'd0);
      chk({name, " we"},    32'(op_rk_we),  32'd0);
   endtask

   // Start a sequence and walk its transfers against the vector table.
   // stall: hold op_ready low for one cycle before every transfer.
   // poke:  pulse start (mode ENC) in the middle of the sequence.
   task automatic run_seq(input string name, input logic [1:0] m, input int base,
                          input int n, input bit stall, input bit poke);
      op_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      chk({name, " busy after start"}, 32'(busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         if (stall) begin
            op_ready = 1'b0;
            chk_op({name, " stall"}, base + k);
            @(negedge clk);
            chk_op({name, " held"}, base + k);
            op_ready = 1'b1;
         end
         chk_op(name, base + k);
         chk({name, " no done"}, 32'(done), 32'd0);
         if (poke && (k == 3)) begin
            start = 1'b1;
            mode  = 2'b01;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, " done in FIN"},  32'(done),     32'd1);
      chk({name, " valid in FIN"}, 32'(op_valid), 32'd0);
      chk({name, " busy in FIN"},  32'(busy),     32'd1);
      chk({name, " err in FIN"},   32'(err),      32'd0);
      @(negedge clk);
      chk({name, " done one cycle"}, 32'(done), 32'd0);
      chk({name, " idle after FIN"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({name, " no second done"}, 32'(done), 32'd0);
      chk({name, " stays idle"},     32'(busy), 32'd0);
   endtask

   // Request a start that must be refused with a one-cycle err pulse
   task automatic reject(input string name, input logic [1:0] m);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      chk({name, " err pulse"}, 32'(err),  32'd1);
      chk({name, " busy"},      32'(busy), 32'd0);
      @(negedge clk);
      chk({name, " err cleared"}, 32'(err), 32'd0);
   endtask

   initial begin
      logic [7:0] rc [10];
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      mode     = 2'b00;
      op_ready = 1'b1;

      rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      // Key schedule
      vt[0] = '{3'd0, 4'd0, 8'h00, 1'b1};
      for (int i = 1; i <= 10; i++) vt[i] = '{3'd2, 4'(i), rc[i-1], 1'b1};
      // Encrypt
      vt[11] = '{3'd1, 4'd0, 8'h00, 1'b0};
      for (int i = 1; i <= 9; i++) vt[11+i] = '{3'd3, 4'(i), 8'h00, 1'b0};
      vt[21] = '{3'd4, 4'd10, 8'h00, 1'b0};
      // Decrypt
      vt[22] = '{3'd1, 4'd10, 8'h00, 1'b0};
      for (int i = 9; i >= 1; i--) begin
         vt[23 + 2*(9-i)] = '{3'd5, 4'(i), 8'h00, 1'b0};
         vt[24 + 2*(9-i)] = '{3'd6, 4'(i), 8'h00, 1'b0};
      end
      vt[41] = '{3'd7, 4'd0, 8'h00, 1'b0};

      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset keys_valid", 32'(keys_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      reject("enc without keys", 2'b01);
      reject("dec without keys", 2'b10);
      reject("reserved mode",    2'b11);

      run_seq("ks", 2'b00, 0, 11, 1'b0, 1'b0);
      chk("keys_valid after ks", 32'(keys_valid), 32'd1);

      run_seq("enc", 2'b01, 11, 11, 1'b0, 1'b1);
      chk("keys_valid after enc", 32'(keys_valid), 32'd1);

      run_seq("dec", 2'b10, 22, 20, 1'b1, 1'b0);

      reject("reserved with keys", 2'b11);

      // Abort a key schedule after its fifth transfer
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b00;
      @(negedge clk);
      start = 1'b0;
      chk("ks2 keys_valid cleared", 32'(keys_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk_op("ks2", k);
         @(negedge clk);
      end
      chk_op("ks2 sixth", 5);
      rst = 1'b1;
      #1;
      chk_idle_outputs("mid reset");
      chk("mid reset keys_valid", 32'(keys_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      reject("enc after abort", 2'b01);
      run_seq("ks3", 2'b00, 0, 11, 1'b0, 1'b0);
      chk("keys_valid after ks3", 32'(keys_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
